// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the pipeline MEM stage.
//   Takes one load/store at a time over valid/ready, does RV32 byte/half/word
//   lane handling and load sign/zero extension, and answers after WAIT_CYCLES
//   wait states. Owns the data RAM, which is not reset.
// Ports:
//   clk, arst_n                  clock (rising edge), async active-low reset
//   req_valid_i / req_ready_o    request handshake; ready only while idle
//   req_we_i, req_addr_i,
//   req_wdata_i, req_funct3_i    access type, byte address, lane-0 store data
//   resp_valid_o / resp_ready_i  response handshake
//   resp_rdata_o, resp_err_o     extended load data (0 for stores), error flag
//   busy_o                       request in flight
// Configuration macro: DMEM_MISALIGN_TRAP_EN
//   defined   -> misaligned half/word accesses are flagged and have no effect
//   undefined -> misaligned accesses are silently aligned down
module dmem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [2:0]        req_funct3_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic              busy_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  // Only consumed when WAIT_CYCLES > 0.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [IDX_W+1:0]  addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] ram_q [DEPTH_WORDS];

  logic              accept_s, commit_s, mem_we_s;
  logic              cur_we_s, illegal_s, trap_s, err_s;
  logic [IDX_W+1:0]  cur_addr_s, eff_addr_s;
  logic [DATA_W-1:0] cur_wdata_s, wlane_s, rd_word_s, shifted_s, ld_s;
  logic [2:0]        cur_f3_s;
  logic [3:0]        be_s;
  logic [IDX_W-1:0]  idx_s;
  logic              unused_s;

  // Address bits above the RAM index wrap and are deliberately ignored.
  assign unused_s = ^req_addr_i[ADDR_W-1:IDX_W+2];

  assign accept_s     = req_valid_i && req_ready_o;
  assign req_ready_o  = (state_q == S_IDLE) && arst_n;
  assign resp_valid_o = (state_q == S_RESP);
  assign busy_o       = (state_q != S_IDLE);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

  // With zero wait states the commit happens on the accept edge, so the live
  // inputs are used; otherwise the values captured at accept.
  assign cur_we_s    = (state_q == S_IDLE) ? req_we_i : we_q;
  assign cur_addr_s  = (state_q == S_IDLE) ? req_addr_i[IDX_W+1:0] : addr_q;
  assign cur_wdata_s = (state_q == S_IDLE) ? req_wdata_i : wdata_q;
  assign cur_f3_s    = (state_q == S_IDLE) ? req_funct3_i : f3_q;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap_s = ((cur_f3_s[1:0] == 2'b01) && cur_addr_s[0]) ||
                  ((cur_f3_s[1:0] == 2'b10) && (cur_addr_s[1:0] != 2'b00));
`else
  assign trap_s = 1'b0;
`endif

  assign err_s     = illegal_s || trap_s;
  assign idx_s     = eff_addr_s[IDX_W+1:2];
  assign rd_word_s = ram_q[idx_s];
  assign shifted_s = rd_word_s >> {eff_addr_s[1:0], 3'b000};
  assign mem_we_s  = commit_s && cur_we_s && !err_s;

  // Access decode: legality, aligned address, store lanes, load extension.
  always_comb begin
    eff_addr_s = cur_addr_s;
    be_s       = 4'b0000;
    wlane_s    = {DATA_W{1'b0}};
    ld_s       = {DATA_W{1'b0}};
    if (cur_we_s) begin
      illegal_s = cur_f3_s[2] || (cur_f3_s[1:0] == 2'b11);
    end else begin
      illegal_s = (cur_f3_s[1:0] == 2'b11) || (cur_f3_s == 3'b110);
    end
    case (cur_f3_s[1:0])
      2'b00: begin
        be_s    = 4'b0001 << cur_addr_s[1:0];
        wlane_s = {4{cur_wdata_s[7:0]}};
      end
      2'b01: begin
        eff_addr_s[0] = 1'b0;
        be_s          = cur_addr_s[1] ? 4'b1100 : 4'b0011;
        wlane_s       = {2{cur_wdata_s[15:0]}};
      end
      2'b10: begin
        eff_addr_s[1:0] = 2'b00;
        be_s            = 4'b1111;
        wlane_s         = cur_wdata_s;
      end
      default: begin
        be_s    = 4'b0000;
        wlane_s = {DATA_W{1'b0}};
      end
    endcase
    case (cur_f3_s)
      3'b000:  ld_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
      3'b001:  ld_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
      3'b010:  ld_s = rd_word_s;
      3'b100:  ld_s = {24'd0, shifted_s[7:0]};
      3'b101:  ld_s = {16'd0, shifted_s[15:0]};
      default: ld_s = {DATA_W{1'b0}};
    endcase
  end

  // Control FSM, request capture and response data selection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    f3_d     = f3_q;
    commit_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i[IDX_W+1:0];
          wdata_d = req_wdata_i;
          f3_d    = req_funct3_i;
          if (WAIT_CYCLES == 0) begin
            state_d  = S_RESP;
            commit_s = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d  = S_RESP;
          commit_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (commit_s) begin
      rdata_d = (cur_we_s || err_s) ? {DATA_W{1'b0}} : ld_s;
      err_d   = err_s;
    end else begin
      rdata_d = rdata_q;
      err_d   = err_q;
    end
  end

  // State and captured-request registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= 3'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Byte-enabled RAM write on the edge entering RESP; contents are not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we_s && be_s[b]) begin
        ram_q[idx_s][8*b +: 8] <= wlane_s[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam int W = 1;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [2:0]  req_f3 = 3'd0;
  logic        resp_ready = 1'b0;
  logic        req_ready_o, resp_valid_o, resp_err_o, busy_o;
  logic [31:0] resp_rdata_o;

  int checks = 0;
  int errors = 0;
  byte unsigned ref_mem [4096];  // byte-addressed image of the whole RAM

  dmem_responder #(.WAIT_CYCLES(W)) u_dut (
    .clk(clk), .arst_n(arst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_funct3_i(req_f3),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: RV32 memory semantics over a flat byte array.
  function automatic void model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                input logic [2:0] f3, output logic [31:0] rd, output logic er);
    int unsigned sz;
    logic [31:0] ea, v;
    bit ill, mis;
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ill = we ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis = (a % sz) != 0;
`ifdef DMEM_MISALIGN_TRAP_EN
    er = ill || mis;
`else
    er = ill;
`endif
    ea = a - (a % sz);
    rd = 32'd0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < int'(sz); i++) ref_mem[(ea + i) % 4096] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < int'(sz); i++) v = v | (32'(ref_mem[(ea + i) % 4096]) << (8*i));
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
        rd = v;
      end
    end
  endfunction

  // One complete transaction, starting and ending just after a falling edge.
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, output logic [31:0] rd, output logic er,
                        output int lat);
    int n;
    req_we = we; req_addr = a; req_wdata = wd; req_f3 = f3; req_valid = 1'b1;
    n = 0;
    while (!req_ready_o && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    // Scramble the request bus after accept: the DUT must use the captured copy.
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_f3 = 3'($urandom);
    lat = 1;
    while (!resp_valid_o && lat < 20) begin @(negedge clk); lat++; end
    rd = resp_rdata_o;
    er = resp_err_o;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic step(input string tag, input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [2:0] f3, output logic [31:0] rd);
    logic [31:0] erd;
    logic er, eer;
    int lat;
    access(we, a, wd, f3, rd, er, lat);
    model(we, a, wd, f3, erd, eer);
    check({tag, ".rdata"}, rd, erd);
    check({tag, ".err"}, {31'd0, er}, {31'd0, eer});
    check({tag, ".latency"}, lat, W + 1);
  endtask

  initial begin
    logic [31:0] rd, erd;
    logic eer;
    int n;

    // Reset state
    #1;
    check("rst.ready", req_ready_o, 1'b0);
    check("rst.valid", resp_valid_o, 1'b0);
    check("rst.rdata", resp_rdata_o, 32'd0);
    check("rst.err", resp_err_o, 1'b0);
    check("rst.busy", busy_o, 1'b0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    #1;
    check("rst.ready_after", req_ready_o, 1'b1);
    @(negedge clk);

    // Give words 0x00..0x3C known contents
    for (int i = 0; i < 16; i++) step("init", 1'b1, 32'(i * 4), $urandom, 3'b010, rd);

    // 1: SW/LW round trip
    step("t1.sw", 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, rd);
    check("t1.sw_rdata_zero", rd, 32'd0);
    step("t1.lw", 1'b0, 32'h10, 32'd0, 3'b010, rd);
    check("t1.lw_value", rd, 32'hDEAD_BEEF);

    // 2: byte store preserves other lanes; signed/unsigned byte loads
    step("t2.sw", 1'b1, 32'h10, 32'h1122_3344, 3'b010, rd);
    step("t2.sb", 1'b1, 32'h13, 32'h0000_0080, 3'b000, rd);
    step("t2.lb", 1'b0, 32'h13, 32'd0, 3'b000, rd);
    check("t2.lb_value", rd, 32'hFFFF_FF80);
    step("t2.lbu", 1'b0, 32'h13, 32'd0, 3'b100, rd);
    check("t2.lbu_value", rd, 32'h0000_0080);
    step("t2.lw", 1'b0, 32'h10, 32'd0, 3'b010, rd);
    check("t2.lw_value", rd, 32'h8022_3344);

    // 3: upper half loads
    step("t3.sw", 1'b1, 32'h10, 32'h8001_5A5A, 3'b010, rd);
    step("t3.lh", 1'b0, 32'h12, 32'd0, 3'b001, rd);
    check("t3.lh_value", rd, 32'hFFFF_8001);
    step("t3.lhu", 1'b0, 32'h12, 32'd0, 3'b101, rd);
    check("t3.lhu_value", rd, 32'h0000_8001);

    // 4: response back-pressure with a second request waiting
    step("t4.sw", 1'b1, 32'h14, 32'h0BAD_CAFE, 3'b010, rd);
    req_we = 1'b0; req_addr = 32'h10; req_f3 = 3'b010; req_valid = 1'b1;
    @(negedge clk);
    req_addr = 32'h14;
    n = 0;
    while (!resp_valid_o && n < 20) begin @(negedge clk); n++; end
    model(1'b0, 32'h10, 32'd0, 3'b010, erd, eer);
    for (int i = 0; i < 5; i++) begin
      check("t4.hold_valid", resp_valid_o, 1'b1);
      check("t4.hold_rdata", resp_rdata_o, erd);
      check("t4.hold_ready", req_ready_o, 1'b0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    check("t4.no_accept_in_resp", req_ready_o, 1'b0);
    @(negedge clk);
    resp_ready = 1'b0;
    check("t4.idle_ready", req_ready_o, 1'b1);
    check("t4.idle_busy", busy_o, 1'b0);
    check("t4.idle_valid", resp_valid_o, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    check("t4.second_accept", busy_o, 1'b1);
    n = 0;
    while (!resp_valid_o && n < 20) begin @(negedge clk); n++; end
    model(1'b0, 32'h14, 32'd0, 3'b010, erd, eer);
    check("t4.second_rdata", resp_rdata_o, erd);
    check("t4.second_value", resp_rdata_o, 32'h0BAD_CAFE);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // 5: misaligned word accesses
    step("t5.sw", 1'b1, 32'h10, 32'hCAFE_F00D, 3'b010, rd);
    step("t5.lw_mis", 1'b0, 32'h11, 32'd0, 3'b010, rd);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("t5.lw_mis_value", rd, 32'd0);
`else
    check("t5.lw_mis_value", rd, 32'hCAFE_F00D);
`endif
    step("t5.sw_mis", 1'b1, 32'h11, 32'h5555_5555, 3'b010, rd);
    step("t5.lw", 1'b0, 32'h10, 32'd0, 3'b010, rd);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("t5.lw_value", rd, 32'hCAFE_F00D);
`else
    check("t5.lw_value", rd, 32'h5555_5555);
`endif
    step("t5.illegal_ld", 1'b0, 32'h10, 32'd0, 3'b110, rd);
    step("t5.illegal_st", 1'b1, 32'h10, 32'hFFFF_FFFF, 3'b011, rd);

    // 6: reset during WAIT of a store drops it
    step("t6.sw", 1'b1, 32'h20, 32'h600D_F00D, 3'b010, rd);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hBAAD_BAAD; req_f3 = 3'b010;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("t6.busy_in_wait", busy_o, 1'b1);
    arst_n = 1'b0;
    #1;
    check("t6.rst_valid", resp_valid_o, 1'b0);
    check("t6.rst_busy", busy_o, 1'b0);
    check("t6.rst_ready", req_ready_o, 1'b0);
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    check("t6.ready_after", req_ready_o, 1'b1);
    @(negedge clk);
    check("t6.no_resp", resp_valid_o, 1'b0);
    step("t6.lw", 1'b0, 32'h20, 32'd0, 3'b010, rd);
    check("t6.word_unchanged", rd, 32'h600D_F00D);

    // Random mix, including wrapped upper address bits and illegal funct3
    for (int i = 0; i < 200; i++) begin
      step("rnd", 1'($urandom), ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)),
           $urandom, 3'($urandom), rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
